vga_timing_controller: RTL and testbench
========================================

# vga_timing_controller

Sequences the VGA raster: owns the horizontal and vertical pixel counters, decodes the active-low HS/VS sync pulses and the display-enable window, and starts or stops scan-out on request. It sits between the pixel-clock enable and the video datapath. Pixel fetch logic consumes HCNT/VCNT/DE, and the monitor connector consumes HS/VS.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT_PORCH, 16, horizontal front porch in pixels
- H_SYNC_PULSE, 96, HS pulse width in pixels
- H_BACK_PORCH, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT_PORCH, 10, vertical front porch in lines
- V_SYNC_PULSE, 2, VS pulse width in lines
- V_BACK_PORCH, 33, vertical back porch in lines
- clk  in  1  system clock; the single clock of the block
- rst  in  1  synchronous, active-low reset
- en  in  1  pixel strobe; the raster advances one pixel per clk with en=1
- start  in  1  level request to begin or resume scan-out
- stop  in  1  level request to stop at the end of the current frame
- HCNT  out  11  horizontal position, 0..H_TOTAL-1
- VCNT  out  11  vertical position, 0..V_TOTAL-1
- HS  out  1  horizontal sync, active low
- VS  out  1  vertical sync, active low
- DE  out  1  high while HCNT < H_VISIBLE and VCNT < V_VISIBLE
- frame_start  out  1  one-clk pulse when the raster is at (0,0) for a new frame
- busy  out  1  high whenever the state is not IDLE

## Operation
- H_TOTAL is the sum of the four H parameters (default 800). V_TOTAL is the sum of the four V parameters (default 525). Both totals must be ≤ 2048; elaboration fails otherwise.
- States:
  - IDLE: counters are held at 0, HS=1, VS=1, DE=0.
  - RUN: the raster advances normally.
  - DRAIN: the raster advances, and the block exits at the end of the frame.
- IDLE to RUN: start=1 at a clk edge. frame_start pulses in the first RUN cycle.
- RUN to DRAIN: stop=1. If start and stop are both high in RUN, stop wins.
- DRAIN to RUN: start=1 and stop=0. The frame continues without restarting.
- DRAIN to IDLE: en=1 at (H_TOTAL-1, V_TOTAL-1). No frame_start is issued.
- Counting (RUN/DRAIN, en=1):
  - HCNT increments, and wraps from H_TOTAL-1 to 0.
  - On that wrap, VCNT increments, and wraps from V_TOTAL-1 to 0.
  - With en=0, all outputs hold their values.
- Sync decode:
  - HS=0 exactly when H_VISIBLE+H_FRONT_PORCH ≤ HCNT < H_VISIBLE+H_FRONT_PORCH+H_SYNC_PULSE.
  - VS=0 exactly when V_VISIBLE+V_FRONT_PORCH ≤ VCNT < V_VISIBLE+V_FRONT_PORCH+V_SYNC_PULSE.
- frame_start in RUN: pulses for the single clk in which the counters become (0,0) after a wrap.

## Timing
- Reset values: state=IDLE, HCNT=0, VCNT=0, HS=1, VS=1, DE=0, frame_start=0, busy=0. All outputs are registered.
- HS, VS and DE are computed from the next-count values and registered. They are therefore aligned, in the same cycle, with the HCNT/VCNT they describe, with zero lag.
- Latency from start to busy=1 is one clk. DE=1 in that same first RUN cycle, because (0,0) is visible.
- Reset asserted mid-frame returns to the reset values on the next edge. Sync outputs are released high, with no partial pulse held.
- frame_start never stays high for more than one clk, even if en stays low after the wrap.

## Configuration
- VGA_LINE_IRQ_EN defined adds three ports:
  - irq_line  in  11  line to match
  - irq_ack  in  1  clears the interrupt
  - line_irq  out  1  sticky interrupt
- line_irq behaviour:
  - Sets when HCNT wraps to 0 with VCNT becoming equal to irq_line.
  - Clears on irq_ack=1.
  - Set wins over a simultaneous irq_ack.
  - Resets to 0, and is forced to 0 in IDLE.
- VGA_LINE_IRQ_EN undefined: the ports and the logic are absent. Behaviour is otherwise identical.

## Structure
- Package vga_timing_pkg holds:
  - the 640x480@60 default constants;
  - the counter width constant (11);
  - the state enum (IDLE, RUN, DRAIN).
- Sub-module vga_axis_counter: one wrapping counter with a carry-in/carry-out, plus sync and visible decode. It is instantiated twice, once horizontal and once vertical; the horizontal carry-out drives the vertical carry-in.

## Test plan
- Reset with rst=0 for 3 clks and en=1: HCNT=VCNT=0, HS=VS=1, DE=0, busy=0, and these hold while start=0.
- start=1 for 1 clk, then en=1 continuously: busy=1 and frame_start=1 after one clk; HS=0 for HCNT 656..751 only; DE=0 from HCNT 640.
- Run 800×525 en strobes: VS=0 for VCNT 490..491 only; frame_start pulses exactly once per 420000 strobes.
- stop=1 at (100,200): raster continues to (799,524), then busy=0 and counters=0, with no frame_start.
- stop at line 300, then start at line 400: raster continues unbroken and busy never drops.
- VGA_LINE_IRQ_EN with irq_line=479: line_irq rises at (0,479). irq_ack on the same edge as a second set keeps line_irq=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing block.
// Holds the 640x480@60 defaults, counter width and FSM state enum.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned MAX_TOTAL = 2048;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT_PORCH = 16;
  localparam int unsigned DEF_H_SYNC_PULSE = 96;
  localparam int unsigned DEF_H_BACK_PORCH = 48;

  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT_PORCH = 10;
  localparam int unsigned DEF_V_SYNC_PULSE = 2;
  localparam int unsigned DEF_V_BACK_PORCH = 33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with carry-in/carry-out and sync/visible decode.
// Ports: clk, rst (sync, active low), clr (hold at 0), inc (carry-in),
//   cnt (position), co (carry-out, combinational), sync_n (registered,
//   active low, decoded from the next count), vis_nxt (next count is visible).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL = 800,
  parameter int unsigned VIS = 640,
  parameter int unsigned SYNC_LO = 656,
  parameter int unsigned SYNC_HI = 752
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             co,
  output logic             sync_n,
  output logic             vis_nxt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_C = CNT_W'(VIS);
  localparam logic [CNT_W-1:0] SLO_C = CNT_W'(SYNC_LO);
  localparam logic [CNT_W-1:0] SHI_C = CNT_W'(SYNC_HI);

  logic [CNT_W-1:0] nxt;
  logic             sync_nxt;

  always_comb begin
    co = inc && (cnt == LAST);
    nxt = cnt;
    if (clr) begin
      nxt = '0;
    end else if (co) begin
      nxt = '0;
    end else if (inc) begin
      nxt = cnt + CNT_W'(1);
    end
    // Decoding the next value keeps sync aligned with the count it describes.
    sync_nxt = !((nxt >= SLO_C) && (nxt < SHI_C));
    vis_nxt = nxt < VIS_C;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      sync_n <= 1'b1;
    end else begin
      cnt <= nxt;
      sync_n <= sync_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: H/V counters, active-low HS/VS, DE, start/stop FSM.
// Ports: clk, rst (sync, active low), en (pixel strobe), start, stop,
//   HCNT, VCNT, HS, VS, DE, frame_start, busy. All outputs registered.
// Option VGA_LINE_IRQ_EN adds irq_line, irq_ack and the sticky line_irq.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int unsigned H_SYNC_PULSE = DEF_H_SYNC_PULSE,
  parameter int unsigned H_BACK_PORCH = DEF_H_BACK_PORCH,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int unsigned V_SYNC_PULSE = DEF_V_SYNC_PULSE,
  parameter int unsigned V_BACK_PORCH = DEF_V_BACK_PORCH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
`ifdef VGA_LINE_IRQ_EN
  input  logic [CNT_W-1:0] irq_line,
  input  logic             irq_ack,
  output logic             line_irq,
`endif
  output logic [CNT_W-1:0] HCNT,
  output logic [CNT_W-1:0] VCNT,
  output logic             HS,
  output logic             VS,
  output logic             DE,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned H_TOTAL =
    H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int unsigned V_TOTAL =
    V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_controller: H_TOTAL/V_TOTAL exceed 2048");
  end

  state_t state;
  state_t state_nxt;

  logic adv;
  logic clr;
  logic h_co;
  logic v_co;
  logic h_vis;
  logic v_vis;
  logic fs_nxt;

  assign adv = en && (state != IDLE);
  assign clr = state == IDLE;

  vga_axis_counter #(
    .TOTAL   (H_TOTAL),
    .VIS     (H_VISIBLE),
    .SYNC_LO (H_VISIBLE + H_FRONT_PORCH),
    .SYNC_HI (H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE)
  ) u_h (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .inc     (adv),
    .cnt     (HCNT),
    .co      (h_co),
    .sync_n  (HS),
    .vis_nxt (h_vis)
  );

  vga_axis_counter #(
    .TOTAL   (V_TOTAL),
    .VIS     (V_VISIBLE),
    .SYNC_LO (V_VISIBLE + V_FRONT_PORCH),
    .SYNC_HI (V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE)
  ) u_v (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .inc     (h_co),
    .cnt     (VCNT),
    .co      (v_co),
    .sync_n  (VS),
    .vis_nxt (v_vis)
  );

  // v_co marks the last pixel of the frame being consumed by a strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (stop) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (start && !stop) begin
          state_nxt = RUN;
        end else if (v_co) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A new frame begins on leaving IDLE or on a wrap that keeps scanning.
    fs_nxt = ((state == IDLE) && (state_nxt == RUN)) ||
             (v_co && (state_nxt != IDLE));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      DE <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state <= state_nxt;
      busy <= state_nxt != IDLE;
      DE <= (state_nxt != IDLE) && h_vis && v_vis;
      frame_start <= fs_nxt;
    end
  end

`ifdef VGA_LINE_IRQ_EN
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] v_after;
  logic             irq_set;

  assign v_after = (VCNT == V_LAST) ? '0 : VCNT + CNT_W'(1);
  assign irq_set = h_co && (v_after == irq_line);

  always_ff @(posedge clk) begin
    if (!rst) begin
      line_irq <= 1'b0;
    end else if (state_nxt == IDLE) begin
      line_irq <= 1'b0;
    end else if (irq_set) begin
      line_irq <= 1'b1;
    end else if (irq_ack) begin
      line_irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_controller.sv
// Scoreboard bench for vga_timing_controller on a reduced raster.
// A pixel-index reference model pushes expectations; a monitor compares.
module tb_vga_timing_controller;

  localparam int HV = 64;
  localparam int HF = 8;
  localparam int HSP = 12;
  localparam int HB = 6;
  localparam int VV = 24;
  localparam int VF = 3;
  localparam int VSP = 2;
  localparam int VB = 5;
  localparam int HT = HV + HF + HSP + HB;
  localparam int VT = VV + VF + VSP + VB;
  localparam int FT = HT * VT;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit de;
    bit fs;
    bit busy;
    bit irq;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic start;
  logic stop;
  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic hs;
  logic vs;
  logic de;
  logic frame_start;
  logic busy;
  logic [10:0] irq_line = 11'(VV - 1);
  logic irq_ack = 1'b0;
`ifdef VGA_LINE_IRQ_EN
  logic line_irq;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int m_mode = 0;
  int m_p = 0;
  bit m_fs = 0;
  bit m_irq = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  vga_timing_controller #(
    .H_VISIBLE     (HV),
    .H_FRONT_PORCH (HF),
    .H_SYNC_PULSE  (HSP),
    .H_BACK_PORCH  (HB),
    .V_VISIBLE     (VV),
    .V_FRONT_PORCH (VF),
    .V_SYNC_PULSE  (VSP),
    .V_BACK_PORCH  (VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .stop        (stop),
`ifdef VGA_LINE_IRQ_EN
    .irq_line    (irq_line),
    .irq_ack     (irq_ack),
    .line_irq    (line_irq),
`endif
    .HCNT        (hcnt),
    .VCNT        (vcnt),
    .HS          (hs),
    .VS          (vs),
    .DE          (de),
    .frame_start (frame_start),
    .busy        (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: raster as a linear pixel index within the frame.
  task automatic model_step();
    int nm;
    bit last;
    bit hw;
    if (!rst) begin
      m_mode = 0;
      m_p = 0;
      m_fs = 0;
      m_irq = 0;
    end else if (m_mode == 0) begin
      m_fs = start;
      if (start) m_mode = 1;
      m_p = 0;
      m_irq = 0;
    end else begin
      nm = m_mode;
      last = en && (m_p == FT - 1);
      hw = en && ((m_p % HT) == HT - 1);
      if (m_mode == 1 && stop) nm = 2;
      else if (m_mode == 2 && start && !stop) nm = 1;
      else if (m_mode == 2 && last) nm = 0;
      if (en) m_p = (m_p + 1) % FT;
      if (nm == 0) m_p = 0;
      m_fs = last && (nm != 0);
      if (nm == 0) m_irq = 0;
      else if (hw && (m_p / HT) == int'(irq_line)) m_irq = 1;
      else if (irq_ack) m_irq = 0;
      m_mode = nm;
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.h = m_p % HT;
    e.v = m_p / HT;
    e.hs = !(e.h >= HV + HF && e.h < HV + HF + HSP);
    e.vs = !(e.v >= VV + VF && e.v < VV + VF + VSP);
    e.busy = m_mode != 0;
    e.de = e.busy && e.h < HV && e.v < VV;
    e.fs = m_fs;
    e.irq = m_irq;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    q.push_back(expect_now());
    #1;
  endtask

  task automatic run_to(input int target, input int maxc, input string nm);
    int n = 0;
    while (m_p != target && n < maxc) begin
      cyc();
      n++;
    end
    chk(nm, m_p, target);
  endtask

  task automatic run_to_idle(input int maxc);
    int n = 0;
    while (m_mode != 0 && n < maxc) begin
      cyc();
      n++;
    end
    chk("drain_to_idle", m_mode, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("HCNT", int'(hcnt), e.h);
      chk("VCNT", int'(vcnt), e.v);
      chk("HS", int'(hs), int'(e.hs));
      chk("VS", int'(vs), int'(e.vs));
      chk("DE", int'(de), int'(e.de));
      chk("frame_start", int'(frame_start), int'(e.fs));
      chk("busy", int'(busy), int'(e.busy));
`ifdef VGA_LINE_IRQ_EN
      chk("line_irq", int'(line_irq), int'(e.irq));
`endif
    end
  end

  initial begin
    rst = 1'b0;
    en = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    repeat (6) begin
      en = 1'($urandom_range(0, 1));
      cyc();
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    en = 1'b1;
    repeat (2 * FT + 10) cyc();
    repeat (FT) begin
      en = ($urandom_range(0, 3) != 0);
      irq_ack = ($urandom_range(0, 7) == 0);
      cyc();
    end
    irq_ack = 1'b0;
    en = 1'b1;
    run_to(12 * HT + 10, 2 * FT, "reach_stop_point");
    stop = 1'b1;
    run_to_idle(2 * FT);
    stop = 1'b0;
    repeat (4) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_to(10 * HT, 2 * FT, "reach_line_10");
    stop = 1'b1;
    run_to(18 * HT, 2 * FT, "reach_line_18");
    stop = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (FT) cyc();
    repeat (8000) begin
      en = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 199) == 0);
      stop = ($urandom_range(0, 299) == 0);
      rst = ($urandom_range(0, 1999) != 0);
      irq_ack = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 999) == 0) irq_line = 11'($urandom_range(0, VT - 1));
      cyc();
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
